// File: rtl/nav_spi_master.sv
// SPI mode-3 master for the navigation sensor cluster (accel/gyro, magnetometer, altimeter).
// One header byte {rw, addr} followed by 1..MAX_BURST data bytes per chip-select window.
module nav_spi_master #(
    parameter int N_CS      = 3,
    parameter int CLK_DIV   = 5,
    parameter int MAX_BURST = 16,
    localparam int CSW   = (N_CS > 1) ? $clog2(N_CS) : 1,
    localparam int LEN_W = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CSW-1:0]   cs_sel,
    input  logic             rw,
    input  logic [6:0]       addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             err,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic             spc,
    output logic             sdi,
    input  logic             sdo,
    output logic [N_CS-1:0]  cs_n
);

    localparam logic [7:0]       DIV_M1  = 8'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             phase_q, phase_d;      // 0: spc low half, 1: spc high half
    logic [2:0]       bit_q, bit_d;
    logic [LEN_W-1:0] byte_q, byte_d;        // 0 = header, 1..len = data
    logic [LEN_W-1:0] len_q, len_d;
    logic             rw_q, rw_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       rx_q, rx_d;
    logic             spc_q, spc_d;
    logic             sdi_q, sdi_d;
    logic [N_CS-1:0]  cs_n_q, cs_n_d;
    logic             err_q, err_d;
    logic             wr_ready_q, wr_ready_d;
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rd_data_q, rd_data_d;

    logic [N_CS-1:0]  sel_dec;
    logic             start_ok;
    logic             cnt_end;

    for (genvar gi = 0; gi < N_CS; gi++) begin : g_sel_dec
        assign sel_dec[gi] = (32'(cs_sel) == gi);
    end

    assign start_ok = (len != '0) && (len <= MAX_LEN) && (32'(cs_sel) < N_CS);
    assign cnt_end  = (cnt_q == DIV_M1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        len_d      = len_q;
        rw_d       = rw_q;
        shreg_d    = shreg_q;
        rx_d       = rx_q;
        spc_d      = spc_q;
        sdi_d      = sdi_q;
        cs_n_d     = cs_n_q;
        rd_data_d  = rd_data_q;
        err_d      = 1'b0;
        wr_ready_d = 1'b0;
        rd_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                spc_d  = 1'b1;
                cs_n_d = '1;
                cnt_d  = '0;
                if (start) begin
                    if (start_ok) begin
                        state_d = S_SETUP;
                        rw_d    = rw;
                        len_d   = len;
                        shreg_d = {rw, addr};
                        cs_n_d  = ~sel_dec;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_SETUP: begin
                if (cnt_end) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                    byte_d  = '0;
                    spc_d   = 1'b0;
                    sdi_d   = shreg_q[7];
                    shreg_d = {shreg_q[6:0], 1'b0};
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_SHIFT: begin
                if (!phase_q) begin
                    if (cnt_end) begin
                        cnt_d   = '0;
                        phase_d = 1'b1;
                        spc_d   = 1'b1;
                        rx_d    = {rx_q[6:0], sdo};
                        if (bit_q == 3'd7 && !rw_q && byte_q != len_q) begin
                            wr_ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    // First high-phase cycle after a byte's 8th rising edge:
                    // capture the write byte or publish the received byte.
                    if (wr_ready_q) begin
                        shreg_d = wr_data;
                    end
                    if (cnt_q == 8'd0 && bit_q == 3'd7 && rw_q && byte_q != '0) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = rx_q;
                    end
                    if (cnt_end) begin
                        cnt_d = '0;
                        if (bit_q == 3'd7 && byte_q == len_q) begin
                            state_d = S_HOLD;
                        end else begin
                            phase_d = 1'b0;
                            spc_d   = 1'b0;
                            sdi_d   = shreg_q[7];
                            shreg_d = {shreg_q[6:0], 1'b0};
                            bit_d   = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                byte_d = byte_q + LEN_W'(1);
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            S_HOLD: begin
                if (cnt_end) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    cs_n_d  = '1;
                    sdi_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_GAP: begin
                if (cnt_end) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cs_n_d  = '1;
                spc_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            bit_q      <= '0;
            byte_q     <= '0;
            len_q      <= '0;
            rw_q       <= 1'b0;
            shreg_q    <= '0;
            rx_q       <= '0;
            spc_q      <= 1'b1;
            sdi_q      <= 1'b0;
            cs_n_q     <= '1;
            err_q      <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            len_q      <= len_d;
            rw_q       <= rw_d;
            shreg_q    <= shreg_d;
            rx_q       <= rx_d;
            spc_q      <= spc_d;
            sdi_q      <= sdi_d;
            cs_n_q     <= cs_n_d;
            err_q      <= err_d;
            wr_ready_q <= wr_ready_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_GAP) && cnt_end;
    assign err      = err_q;
    assign wr_ready = wr_ready_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign spc      = spc_q;
    assign sdi      = sdi_q;
    assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_nav_spi_master.sv
// Bench for nav_spi_master: table of transactions against a mode-3 sensor model,
// plus reset-abort and exact-timing sequences at CLK_DIV=5 and CLK_DIV=2.
module tb_nav_spi_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [1:0] cs_sel = '0;
    logic       rw = 1'b0;
    logic [6:0] addr = '0;
    logic [4:0] len = '0;
    logic [7:0] wr_data = '0;
    logic       sdo = 1'b0;
    logic       sdo_b = 1'b0;

    logic       busy_a, err_a, wr_ready_a, rd_valid_a, done_a, spc_a, sdi_a;
    logic [7:0] rd_data_a;
    logic [2:0] cs_n_a;
    logic       busy_b, err_b, wr_ready_b, rd_valid_b, done_b, spc_b, sdi_b;
    logic [7:0] rd_data_b;
    logic [2:0] cs_n_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nav_spi_master #(.N_CS(3), .CLK_DIV(5), .MAX_BURST(16)) u_dut (
        .clk(clk), .rst(rst), .start(start_a), .cs_sel(cs_sel), .rw(rw), .addr(addr),
        .len(len), .busy(busy_a), .err(err_a), .wr_data(wr_data), .wr_ready(wr_ready_a),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .done(done_a), .spc(spc_a),
        .sdi(sdi_a), .sdo(sdo), .cs_n(cs_n_a)
    );

    nav_spi_master #(.N_CS(3), .CLK_DIV(2), .MAX_BURST(16)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_b), .cs_sel(cs_sel), .rw(rw), .addr(addr),
        .len(len), .busy(busy_b), .err(err_b), .wr_data(wr_data), .wr_ready(wr_ready_b),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .done(done_b), .spc(spc_b),
        .sdi(sdi_b), .sdo(sdo_b), .cs_n(cs_n_b)
    );

    // Timing probes select one of the two instances.
    logic       tsel = 1'b0;
    logic       m_busy, m_spc, m_done;
    logic [2:0] m_csn;
    assign m_busy = tsel ? busy_b : busy_a;
    assign m_spc  = tsel ? spc_b  : spc_a;
    assign m_done = tsel ? done_b : done_a;
    assign m_csn  = tsel ? cs_n_b : cs_n_a;

    // Sensor model for the main instance: shifts sdo out after each spc fall,
    // captures sdi at each spc rise, restarts when chip select drops.
    logic [7:0] miso_bytes [0:16];
    logic       mosi_bits  [0:135];
    int         fall_cnt = 0;
    int         rise_cnt = 0;
    logic       prev_spc = 1'b1;
    logic       prev_csh = 1'b1;

    always @(negedge clk) begin
        logic       csh;
        logic [7:0] mb;
        csh = &cs_n_a;
        if (prev_csh && !csh) begin
            fall_cnt = 0;
            rise_cnt = 0;
        end
        if (!csh) begin
            if (prev_spc && !spc_a) begin
                mb  = miso_bytes[(fall_cnt / 8) % 17];
                sdo = mb[7 - (fall_cnt % 8)];
                fall_cnt++;
            end
            if (!prev_spc && spc_a && rise_cnt < 136) begin
                mosi_bits[rise_cnt] = sdi_a;
                rise_cnt++;
            end
        end
        prev_spc = spc_a;
        prev_csh = csh;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  cs;
        logic        rw;
        logic [6:0]  addr;
        logic [4:0]  len;
        logic [47:0] data;
        logic [7:0]  exp_hdr;
        logic [2:0]  exp_csn;
        logic        exp_err;
        logic        poke;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [7:0] dbyte(input logic [47:0] d, input int k);
        return d[47 - 8*k -: 8];
    endfunction

    task automatic kick(input logic [1:0] c, input logic r, input logic [6:0] a, input logic [4:0] l);
        @(posedge clk); #1;
        cs_sel = c; rw = r; addr = a; len = l; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int busy_cnt, dones, done_at, errs, csbad, cslow, wr_cnt, rd_cnt, rdbad, mbad, exp_busy;
        logic [7:0] mb, eb;
        busy_cnt = 0; dones = 0; done_at = 0; errs = 0; csbad = 0; cslow = 0;
        wr_cnt = 0; rd_cnt = 0; rdbad = 0; mbad = 0;
        miso_bytes[0] = 8'h00;
        for (int b = 0; b < 16; b++) miso_bytes[b+1] = (b < 6) ? dbyte(v.data, b) : 8'h00;
        kick(v.cs, v.rw, v.addr, v.len);
        if (v.exp_err) begin
            chk($sformatf("v%0d err_pulse", idx), {err_a, busy_a}, 2'b10);
            @(negedge clk);
            chk($sformatf("v%0d err_clear", idx), {err_a, busy_a, cs_n_a, spc_a}, {2'b00, 3'b111, 1'b1});
            $display("vec %0d: reject cs=%0d len=%0d", idx, v.cs, v.len);
            return;
        end
        chk($sformatf("v%0d accept", idx), {err_a, busy_a}, 2'b01);
        for (int c = 0; c < 4000 && busy_a; c++) begin
            busy_cnt++;
            if (done_a) begin dones++; done_at = busy_cnt; end
            if (err_a) errs++;
            if (!(&cs_n_a)) begin
                cslow++;
                if (cs_n_a != v.exp_csn) csbad++;
            end
            if (wr_ready_a) begin
                wr_data = (wr_cnt < 6) ? dbyte(v.data, wr_cnt) : 8'h00;
                wr_cnt++;
            end
            if (rd_valid_a) begin
                if (rd_cnt >= 6 || rd_data_a != dbyte(v.data, rd_cnt)) rdbad++;
                rd_cnt++;
            end
            if (v.poke && busy_cnt == 40) begin
                start_a = 1'b1; len = 5'd0; cs_sel = 2'd3;
            end else if (v.poke && busy_cnt == 41) begin
                start_a = 1'b0;
            end
            @(negedge clk);
        end
        if (err_a) errs++;
        exp_busy = 5 * (3 + 16 * (int'(v.len) + 1));
        chk($sformatf("v%0d busy_drop", idx), busy_a, 1'b0);
        chk($sformatf("v%0d busy_cycles", idx), busy_cnt, exp_busy);
        chk($sformatf("v%0d done_once_last", idx), {dones[7:0], done_at[15:0]}, {8'd1, exp_busy[15:0]});
        chk($sformatf("v%0d no_err", idx), errs, 0);
        chk($sformatf("v%0d cs_n", idx), {csbad[15:0], cslow[15:0]}, {16'd0, 16'(exp_busy - 5)});
        chk($sformatf("v%0d wr_ready_cnt", idx), wr_cnt, v.rw ? 0 : int'(v.len));
        chk($sformatf("v%0d rd_valid_cnt", idx), {rd_cnt[15:0], rdbad[15:0]},
            {16'(v.rw ? int'(v.len) : 0), 16'd0});
        chk($sformatf("v%0d sdi_bits", idx), rise_cnt, 8 * (int'(v.len) + 1));
        for (int b = 0; b <= int'(v.len) && b < 17; b++) begin
            for (int k = 0; k < 8; k++) mb[7-k] = mosi_bits[8*b + k];
            eb = (b == 0) ? v.exp_hdr : (v.rw ? 8'h00 : dbyte(v.data, b - 1));
            if (mb !== eb) mbad++;
        end
        chk($sformatf("v%0d sdi_stream", idx), mbad, 0);
        $display("vec %0d: cs=%0d rw=%0d addr=%02h len=%0d busy=%0d rd=%0d wr=%0d",
                 idx, v.cs, v.rw, v.addr, v.len, busy_cnt, rd_cnt, wr_cnt);
    endtask

    logic t_spc  [0:1023];
    logic t_csh  [0:1023];
    logic t_done [0:1023];

    task automatic timing_run(input logic sel, input int d);
        int n, j, run, lows, bad, last_high, gap_ok, setup_len, dones, done_at;
        n = 0; lows = 0; bad = 0; last_high = 0; gap_ok = 0; dones = 0; done_at = -1;
        tsel = sel;
        @(posedge clk); #1;
        cs_sel = 2'd0; rw = 1'b1; addr = 7'h0F; len = 5'd1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        @(negedge clk);
        while (n < 1024 && m_busy) begin
            t_spc[n] = m_spc; t_csh[n] = &m_csn; t_done[n] = m_done;
            if (m_done) begin dones++; done_at = n; end
            n++;
            @(negedge clk);
        end
        chk($sformatf("D%0d timeout", d), m_busy, 1'b0);
        chk($sformatf("D%0d latency", d), n, d * (3 + 16 * 2));
        chk($sformatf("D%0d done_last", d), {dones[7:0], done_at[15:0]}, {8'd1, 16'(n - 1)});
        j = 0;
        while (j < n && t_spc[j] && !t_csh[j]) j++;
        setup_len = j;
        chk($sformatf("D%0d setup", d), setup_len, d);
        while (j < n && !t_csh[j]) begin
            run = 0;
            if (!t_spc[j]) begin
                while (j < n && !t_spc[j] && !t_csh[j]) begin run++; j++; end
                lows++;
                if (run != d) bad++;
            end else begin
                while (j < n && t_spc[j] && !t_csh[j]) begin run++; j++; end
                if (j < n && !t_csh[j]) begin
                    if (run != d) bad++;
                end else begin
                    last_high = run;
                end
            end
        end
        chk($sformatf("D%0d spc_bits", d), lows, 16);
        chk($sformatf("D%0d spc_halfperiod", d), bad, 0);
        chk($sformatf("D%0d hold", d), last_high, 2 * d);
        for (int k = j; k < n; k++) if (t_csh[k] && t_spc[k]) gap_ok++;
        chk($sformatf("D%0d gap", d), {gap_ok[15:0], 16'(n - j)}, {16'(d), 16'(d)});
        $display("timing D=%0d: latency=%0d setup=%0d bits=%0d hold+last_high=%0d gap=%0d",
                 d, n, setup_len, lows, last_high, n - j);
        tsel = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        vecs[0] = '{2'd0, 1'b1, 7'h0F, 5'd1,  48'h68_00_00_00_00_00, 8'h8F, 3'b110, 1'b0, 1'b0};
        vecs[1] = '{2'd1, 1'b1, 7'h68, 5'd6,  48'h01_02_03_04_05_06, 8'hE8, 3'b101, 1'b0, 1'b0};
        vecs[2] = '{2'd2, 1'b0, 7'h20, 5'd2,  48'hC4_0C_00_00_00_00, 8'h20, 3'b011, 1'b0, 1'b0};
        vecs[3] = '{2'd0, 1'b1, 7'h0F, 5'd0,  48'h0,                 8'h00, 3'b111, 1'b1, 1'b0};
        vecs[4] = '{2'd3, 1'b1, 7'h0F, 5'd1,  48'h0,                 8'h00, 3'b111, 1'b1, 1'b0};
        vecs[5] = '{2'd1, 1'b0, 7'h11, 5'd17, 48'h0,                 8'h00, 3'b111, 1'b1, 1'b0};
        vecs[6] = '{2'd0, 1'b1, 7'h10, 5'd2,  48'hAA_BB_00_00_00_00, 8'h90, 3'b110, 1'b0, 1'b1};
        vecs[7] = '{2'd1, 1'b0, 7'h55, 5'd3,  48'hA5_5A_FF_00_00_00, 8'h55, 3'b101, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_a", {cs_n_a, spc_a, sdi_a, busy_a, err_a, wr_ready_a, rd_valid_a, done_a, rd_data_a},
            {3'b111, 1'b1, 6'b0, 8'h00});
        chk("reset_b", {cs_n_b, spc_b, sdi_b, busy_b, err_b, wr_ready_b, rd_valid_b, done_b, rd_data_b},
            {3'b111, 1'b1, 6'b0, 8'h00});
        $display("reset: cs_n=%b spc=%b busy=%b", cs_n_a, spc_a, busy_a);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset in the third data byte of a 4-byte read must abort silently.
        for (int b = 0; b < 17; b++) miso_bytes[b] = 8'h00;
        kick(2'd1, 1'b1, 7'h28, 5'd4);
        for (int c = 0; c < 2000 && rise_cnt < 26; c++) @(negedge clk);
        chk("abort_reach_byte3", (rise_cnt >= 26), 1'b1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_state", {cs_n_a, spc_a, busy_a, done_a}, {3'b111, 1'b1, 1'b0, 1'b0});
        dn = 0;
        for (int c = 0; c < 30; c++) begin
            if (done_a || busy_a) dn++;
            @(negedge clk);
        end
        chk("abort_quiet", dn, 0);
        $display("abort: cs_n=%b spc=%b busy=%b", cs_n_a, spc_a, busy_a);
        run_vec(8, vecs[0]);

        timing_run(1'b0, 5);
        timing_run(1'b1, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
